// File: rtl/mips_bus_access_unit.sv
// mips_bus_access_unit
//   Bus master between the multicycle MIPS datapath and the Avalon-style
//   memory bus. Arbitrates fetch vs. data requests (data wins), holds the
//   bus cycle stable across waitrequest, builds byte lanes for sub-word
//   stores, extends load data and reports misalignment / bus timeout.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   if_req/if_addr    : fetch request in; if_ready/if_instr/if_err out
//   d_req/d_we/d_size/d_signed/d_addr/d_wdata : data request in
//   d_ready/d_rdata/d_err : data response out
//   address/read/write/byteenable/writedata   : bus master outputs
//   waitrequest/readdata                      : bus slave inputs

// One byte lane of the store path: lane enable and the byte routed onto it.
module mbau_lane #(
    parameter int LANE  = 0,
    parameter int VEC_W = 8
) (
    input  logic [1:0]       i_size,
    input  logic [1:0]       i_off,
    input  logic [4*VEC_W-1:0] i_wdata,
    output logic             o_be,
    output logic [VEC_W-1:0] o_byte
);
    localparam logic [1:0] L = LANE[1:0];

    always_comb begin
        o_be   = 1'b1;
        o_byte = i_wdata[VEC_W*LANE +: VEC_W];
        case (i_size)
            2'b00: begin
                o_be   = (i_off == L);
                o_byte = i_wdata[VEC_W-1:0];
            end
            2'b01: begin
                // half selects upper or lower lane pair by offset bit 1
                o_be   = (i_off[1] == L[1]);
                o_byte = i_wdata[VEC_W*(LANE%2) +: VEC_W];
            end
            default: ;
        endcase
    end
endmodule

module mips_bus_access_unit #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_instr,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam int CW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUS_RD, BUS_WR, RESP} state_t;

    // Attributes of the transaction in flight, needed again at completion.
    typedef struct packed {
        logic       is_d;
        logic [1:0] size;
        logic       sgn;
        logic [1:0] off;
    } xact_t;

    state_t      r_state, w_state;
    xact_t       r_x, w_x;
    logic [31:0] r_address, w_address;
    logic        r_read, w_read;
    logic        r_write, w_write;
    logic [3:0]  r_be, w_be;
    logic [31:0] r_wdata, w_wdata;
    logic [31:0] r_rdata, w_rdata;
    logic        r_err, w_err;
    logic [CW-1:0] r_cnt, w_cnt;

    // Selected request (data has priority over fetch)
    logic [31:0] w_req_addr;
    logic [1:0]  w_req_size;
    logic        w_misalign;

    logic [NUM_LANES-1:0]            w_lane_be;
    logic [NUM_LANES-1:0][VEC_W-1:0] w_lane_byte;

    always_comb begin
        w_req_addr = d_req ? d_addr : if_addr;
        w_req_size = d_req ? d_size : 2'b10;
        case (w_req_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = w_req_addr[0];
            default: w_misalign = (w_req_addr[1:0] != 2'b00);
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            mbau_lane #(.LANE(gi), .VEC_W(VEC_W)) u_lane (
                .i_size  (w_req_size),
                .i_off   (w_req_addr[1:0]),
                .i_wdata (d_wdata),
                .o_be    (w_lane_be[gi]),
                .o_byte  (w_lane_byte[gi])
            );
        end
    endgenerate

    function automatic logic [31:0] extract(input logic [31:0] rd, input xact_t x);
        logic [31:0] sh;
        sh = rd >> {x.off, 3'b000};
        if (!x.is_d) return rd;
        case (x.size)
            2'b00:   return {{24{x.sgn & sh[7]}},  sh[7:0]};
            2'b01:   return {{16{x.sgn & sh[15]}}, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    always_comb begin
        w_state   = r_state;
        w_x       = r_x;
        w_address = r_address;
        w_read    = r_read;
        w_write   = r_write;
        w_be      = r_be;
        w_wdata   = r_wdata;
        w_rdata   = r_rdata;
        w_err     = r_err;
        w_cnt     = r_cnt;
        case (r_state)
            IDLE: begin
                if (d_req || if_req) begin
                    w_x.is_d = d_req;
                    w_x.size = w_req_size;
                    w_x.sgn  = d_req & d_signed;
                    w_x.off  = w_req_addr[1:0];
                    w_cnt    = '0;
                    if (w_misalign) begin
                        w_state = RESP;
                        w_err   = 1'b1;
                        w_rdata = '0;
                    end else begin
                        w_err     = 1'b0;
                        w_address = {w_req_addr[31:2], 2'b00};
                        w_be      = w_lane_be;
                        w_wdata   = w_lane_byte;
                        if (d_req && d_we) begin
                            w_write = 1'b1;
                            w_state = BUS_WR;
                        end else begin
                            w_read  = 1'b1;
                            w_state = BUS_RD;
                        end
                    end
                end
            end
            BUS_RD, BUS_WR: begin
                if (!waitrequest) begin
                    w_read  = 1'b0;
                    w_write = 1'b0;
                    w_state = RESP;
                    w_rdata = (r_state == BUS_RD) ? extract(readdata, r_x) : '0;
                end else if (TIMEOUT_CYCLES != 0 && r_cnt == TO_LAST) begin
                    w_read  = 1'b0;
                    w_write = 1'b0;
                    w_state = RESP;
                    w_err   = 1'b1;
                    w_rdata = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            RESP: w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_x       <= '0;
            r_address <= '0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state;
            r_x       <= w_x;
            r_address <= w_address;
            r_read    <= w_read;
            r_write   <= w_write;
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_rdata   <= w_rdata;
            r_err     <= w_err;
            r_cnt     <= w_cnt;
        end
    end

    assign address    = r_address;
    assign read       = r_read;
    assign write      = r_write;
    assign byteenable = r_be;
    assign writedata  = r_wdata;
    assign if_ready   = (r_state == RESP) & ~r_x.is_d;
    assign d_ready    = (r_state == RESP) &  r_x.is_d;
    assign if_err     = if_ready & r_err;
    assign d_err      = d_ready & r_err;
    assign if_instr   = r_rdata;
    assign d_rdata    = r_rdata;
endmodule

// File: tb/tb_mips_bus_access_unit.sv
// Directed bench for mips_bus_access_unit (TIMEOUT_CYCLES=8).
module tb_mips_bus_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_instr;
    logic        if_err;
    logic        d_req, d_we, d_signed;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] address;
    logic        read, write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    int n_chk  = 0;
    int n_pass = 0;
    logic both_seen = 1'b0;

    mips_bus_access_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_instr(if_instr), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
        .d_rdata(d_rdata), .d_err(d_err),
        .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (read && write) both_seen <= 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_signed = 0;
        d_size = 0; d_addr = 0; d_wdata = 0; waitrequest = 0; readdata = 0;
        tick(); tick();
        check("rst_read", {31'd0, read}, 0);
        check("rst_write", {31'd0, write}, 0);
        check("rst_addr", address, 0);
        check("rst_be", {28'd0, byteenable}, 0);
        check("rst_wdata", writedata, 0);
        check("rst_rdy", {30'd0, if_ready, d_ready}, 0);
        check("rst_err", {30'd0, if_err, d_err}, 0);
        reset = 1'b0;
        tick();

        // fetch, no wait states
        if_req = 1; if_addr = 32'hBFC00000; readdata = 32'h24020005;
        tick();
        check("f_read", {31'd0, read}, 1);
        check("f_addr", address, 32'hBFC00000);
        check("f_be", {28'd0, byteenable}, 4'hF);
        check("f_rdy_early", {31'd0, if_ready}, 0);
        tick();
        check("f_read_drop", {31'd0, read}, 0);
        check("f_rdy", {31'd0, if_ready}, 1);
        check("f_instr", if_instr, 32'h24020005);
        check("f_err", {31'd0, if_err}, 0);
        if_req = 0;
        tick();
        check("f_rdy_pulse", {31'd0, if_ready}, 0);

        // signed byte load with 3 wait cycles
        d_req = 1; d_we = 0; d_size = 2'b00; d_signed = 1; d_addr = 32'h1003;
        readdata = 32'h80FFFFFF; waitrequest = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("sb_read", {31'd0, read}, 1);
            check("sb_addr", address, 32'h1000);
            check("sb_be", {28'd0, byteenable}, 4'b1000);
            check("sb_nordy", {31'd0, d_ready}, 0);
            tick();
        end
        check("sb_read4", {31'd0, read}, 1);
        waitrequest = 0;
        tick();
        check("sb_rdy", {31'd0, d_ready}, 1);
        check("sb_data", d_rdata, 32'hFFFFFF80);
        check("sb_read_drop", {31'd0, read}, 0);
        d_req = 0;
        tick();
        check("sb_rdy_pulse", {31'd0, d_ready}, 0);

        // unsigned repeat
        d_req = 1; d_signed = 0;
        tick(); tick();
        check("ub_rdy", {31'd0, d_ready}, 1);
        check("ub_data", d_rdata, 32'h00000080);
        d_req = 0;
        tick();

        // half store at 0x2002
        d_req = 1; d_we = 1; d_size = 2'b01; d_addr = 32'h2002; d_wdata = 32'h0000BEEF;
        tick();
        check("hs_write", {31'd0, write}, 1);
        check("hs_read", {31'd0, read}, 0);
        check("hs_be", {28'd0, byteenable}, 4'b1100);
        check("hs_wd", {16'd0, writedata[31:16]}, 32'hBEEF);
        check("hs_addr", address, 32'h2000);
        tick();
        check("hs_rdy", {31'd0, d_ready}, 1);
        check("hs_err", {31'd0, d_err}, 0);
        check("hs_wr_drop", {31'd0, write}, 0);
        d_req = 0;
        tick();

        // byte store at 0x7001
        d_req = 1; d_we = 1; d_size = 2'b00; d_addr = 32'h7001; d_wdata = 32'h000000A5;
        tick();
        check("bs_be", {28'd0, byteenable}, 4'b0010);
        check("bs_wd", {24'd0, writedata[15:8]}, 32'hA5);
        tick();
        check("bs_rdy", {31'd0, d_ready}, 1);
        d_req = 0;
        tick();

        // misaligned half at 0x2001
        d_req = 1; d_we = 1; d_size = 2'b01; d_addr = 32'h2001;
        tick();
        check("mh_strobe", {30'd0, read, write}, 0);
        check("mh_rdy", {31'd0, d_ready}, 1);
        check("mh_err", {31'd0, d_err}, 1);
        d_req = 0;
        tick();
        check("mh_rdy_pulse", {31'd0, d_ready}, 0);

        // both requests: data first, then fetch
        d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h3000; readdata = 32'h11223344;
        if_req = 1; if_addr = 32'h400;
        tick();
        check("ar_d_addr", address, 32'h3000);
        check("ar_d_read", {31'd0, read}, 1);
        tick();
        check("ar_d_rdy", {31'd0, d_ready}, 1);
        check("ar_if_nordy", {31'd0, if_ready}, 0);
        check("ar_d_data", d_rdata, 32'h11223344);
        d_req = 0;
        tick();
        check("ar_idle_read", {31'd0, read}, 0);
        readdata = 32'hAABBCCDD;
        tick();
        check("ar_f_read", {31'd0, read}, 1);
        check("ar_f_addr", address, 32'h400);
        tick();
        check("ar_f_rdy", {31'd0, if_ready}, 1);
        check("ar_f_instr", if_instr, 32'hAABBCCDD);
        if_req = 0;
        tick();

        // timeout after 8 stalled cycles
        d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h5000; waitrequest = 1;
        tick();
        for (int k = 1; k < 8; k++) begin
            tick();
            check("to_read", {31'd0, read}, 1);
            check("to_nordy", {31'd0, d_ready}, 0);
        end
        tick();
        check("to_read_drop", {31'd0, read}, 0);
        check("to_rdy", {31'd0, d_ready}, 1);
        check("to_err", {31'd0, d_err}, 1);
        d_req = 0;
        tick();

        // reset during a stalled read
        d_req = 1; d_addr = 32'h6000; waitrequest = 1;
        tick();
        check("rs_read", {31'd0, read}, 1);
        tick();
        reset = 1; d_req = 0;
        tick();
        check("rs_read_drop", {31'd0, read}, 0);
        check("rs_nordy", {30'd0, if_ready, d_ready}, 0);
        reset = 0; waitrequest = 0;
        tick();
        check("rs_nordy2", {30'd0, if_ready, d_ready}, 0);
        if_req = 1; if_addr = 32'h10; readdata = 32'h8C430004;
        tick();
        check("rs_f_read", {31'd0, read}, 1);
        tick();
        check("rs_f_rdy", {31'd0, if_ready}, 1);
        check("rs_f_instr", if_instr, 32'h8C430004);
        check("rs_f_err", {31'd0, if_err}, 0);
        if_req = 0;
        tick();

        check("rw_exclusive", {31'd0, both_seen}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mips_bus_access_unit.md
Name: mips_bus_access_unit

Overview:
- Bus master between the multicycle MIPS core datapath and the Avalon-style memory bus exported by the CPU (`address`/`read`/`write`/`waitrequest`/`byteenable`/`readdata`/`writedata`).
- Arbitrates instruction-fetch and data-access requests, holds bus signals stable across waitrequest stalls, and generates byte lanes for byte/half/word accesses.
- Sign- or zero-extends load data and flags misaligned accesses and bus timeouts.

Parameters:
- `TIMEOUT_CYCLES`, 1024: consecutive waitrequest-stalled cycles before abort; 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `if_req`  in  1  fetch request, held until `if_ready`
- `if_addr`  in  32  fetch byte address
- `if_ready`  out  1  one-cycle pulse: fetch complete
- `if_instr`  out  32  fetched word, valid while `if_ready`=1
- `if_err`  out  1  valid with `if_ready`: misaligned or timeout
- `d_req`  in  1  data request, held until `d_ready`
- `d_we`  in  1  1=store, 0=load
- `d_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `d_signed`  in  1  sign-extend load result
- `d_addr`  in  32  data byte address
- `d_wdata`  in  32  store data, right-justified
- `d_ready`  out  1  one-cycle pulse: data access complete
- `d_rdata`  out  32  extended load data, valid while `d_ready`=1
- `d_err`  out  1  valid with `d_ready`: misaligned or timeout
- `address`  out  32  word-aligned bus address (bits[1:0]=00)
- `read`  out  1  bus read strobe
- `write`  out  1  bus write strobe
- `byteenable`  out  4  active byte lanes
- `writedata`  out  32  lane-aligned store data
- `waitrequest`  in  1  slave stall
- `readdata`  in  32  bus read data, sampled on completion edge

Behaviour:
- Reset (synchronous): state IDLE; `read`=`write`=0; `if_ready`=`d_ready`=0; `if_err`=`d_err`=0; `address`=0; `byteenable`=0; `writedata`=0; timeout counter=0.
- Reset asserted mid-transaction: strobes drop at that edge; the transaction is abandoned with no ready pulse.
- States: IDLE, BUS_RD, BUS_WR, RESP.
- IDLE arbitration at each edge:
  - `d_req`=1 → data access.
  - Otherwise `if_req`=1 → fetch.
  - Data has priority when both are high.
  - The losing request stays pending and is served after the current RESP.
- Misaligned access: half with addr[0]=1, or word/fetch with addr[1:0]≠00.
  - No bus cycle is issued. Go straight to RESP with err=1; rdata/instr=0.
- Aligned access: at the sampling edge register `address`={addr[31:2],2'b00}, `byteenable`, and `writedata`; assert `read` (load/fetch → BUS_RD) or `write` (store → BUS_WR).
- Byte lanes, little-endian, offset o=addr[1:0]:
  - byte: `byteenable`=1<<o; store data byte placed at lane o.
  - half: `byteenable`=0011 (o=0) or 1100 (o=2).
  - word/fetch: `byteenable`=1111.
- BUS_RD/BUS_WR hold `address`, `byteenable`, `writedata`, and the strobe stable while `waitrequest`=1.
- Completion is the first edge with strobe=1 and `waitrequest`=0. On that edge:
  - Capture `readdata`.
  - Drop the strobe.
  - Go to RESP.
- Timeout: a counter increments each stalled cycle. When it reaches `TIMEOUT_CYCLES` (≠0):
  - Drop the strobe.
  - Go to RESP with err=1.
- RESP: exactly one cycle.
  - Raise the relevant ready (plus err, data); the other ready stays 0.
  - Next state is IDLE.
  - Requests are not sampled in RESP. The requester drops or changes req on seeing ready.
- Load extraction: lane o selected; width per `d_size`; zero- or sign-extended per `d_signed`. Fetch returns the full word unmodified.
- Latency with no wait states: request sampled at E0, strobe high during E0→E1, completion at E1, ready high E1→E2, IDLE at E2. Three cycles per access; each waitrequest cycle adds one.
- `read` and `write` are never high together. Neither strobe is high outside BUS_RD/BUS_WR.

Test Plan:
- Fetch `if_addr`=0xBFC00000, `readdata`=0x24020005, no wait → `read`=1 one cycle with `address`=0xBFC00000 and `byteenable`=1111; `if_ready`=1 two edges after sampling; `if_instr`=0x24020005; `if_err`=0.
- Signed byte load `d_addr`=0x1003, `readdata`=0x80FFFFFF, waitrequest high 3 cycles → `address`=0x1000 and `byteenable`=1000 held 4 cycles; `d_rdata`=0xFFFFFF80. Repeat with `d_signed`=0 → 0x00000080.
- Half store `d_addr`=0x2002, `d_wdata`=0x0000BEEF → `write`=1, `byteenable`=1100, `writedata`[31:16]=0xBEEF; `d_ready` pulse one cycle after completion. Half at 0x2001 → no strobe; `d_ready`=`d_err`=1 next cycle.
- `if_req` and `d_req` both high in IDLE → data access served first; fetch issued on the bus after RESP; `read`&`write` never both 1 throughout.
- `waitrequest` stuck at 1 with `TIMEOUT_CYCLES`=8 → strobe drops after 8 stalled cycles; `d_err`=1 with `d_ready`.
- Reset asserted during a stalled read → `read`=0 at the next edge; no ready pulse; a subsequent fetch completes normally.
